// File: rtl/cpu_ifetch_prefetch.sv
// Instruction prefetch unit: keeps icache reads in flight and queues returns.
// Ports: i_clk/i_reset, redirect (i_pc_load/i_ext_pc), decode handshake
// (o_valid/i_ready/o_pc/o_instruction), icache request/response, o_busy.
package rapid_pkg;
  localparam logic [31:0] RESET_VECTOR     = 32'h0000_0000;
  localparam logic [31:0] NOOP_INSTRUCTION = 32'h0000_0013;
endpackage

module cpu_ifetch_prefetch
  import rapid_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_VECTOR)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_pc_load,
  input  logic [XLEN-1:0] i_ext_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_instruction,
  output logic            o_req_valid,
  input  logic            i_req_ready,
  output logic [XLEN-1:0] o_req_addr,
  input  logic            i_rsp_valid,
  input  logic [XLEN-1:0] i_rsp_data,
  output logic            o_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW =
    (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int SW = CW + OW + 1;
  localparam logic [XLEN-1:0] NOOP = XLEN'(NOOP_INSTRUCTION);

  logic [XLEN-1:0] fetch_pc;
  logic [OW-1:0]   inflight;
  logic [OW-1:0]   inflight_nx;
  logic [OW-1:0]   drop_cnt;
  logic [OW-1:0]   live;
  logic [SW-1:0]   occ;

  logic [XLEN-1:0] pcq [MAX_OUTSTANDING];
  logic [PW-1:0]   pcq_wr;
  logic [PW-1:0]   pcq_rd;

  logic [XLEN-1:0] fq_pc  [FIFO_DEPTH];
  logic [XLEN-1:0] fq_ins [FIFO_DEPTH];
  logic [AW-1:0]   fq_wr;
  logic [AW-1:0]   fq_rd;
  logic [CW-1:0]   fq_cnt;

  logic req_fire;
  logic rsp_fire;
  logic out_fire;
  logic push;
  logic pop;
  logic unused_ext_lo;

  assign unused_ext_lo = ^i_ext_pc[1:0];

  function automatic logic [PW-1:0] pcq_inc(
    input logic [PW-1:0] p
  );
    if (p == PW'(MAX_OUTSTANDING - 1))
      return '0;
    return p + PW'(1);
  endfunction

  assign live = inflight - drop_cnt;
  assign occ  = SW'(live) + SW'(fq_cnt);

  // Credits come from registered state only, so a raised
  // request stays stable until it fires or a redirect hits.
  assign o_req_valid = !i_reset
    && (inflight < OW'(MAX_OUTSTANDING))
    && (occ < SW'(FIFO_DEPTH));
  assign o_req_addr  = fetch_pc;

  assign o_valid       = (fq_cnt != '0);
  assign o_pc          = o_valid ? fq_pc[fq_rd]  : '0;
  assign o_instruction = o_valid ? fq_ins[fq_rd] : NOOP;
  assign o_busy        = (inflight != '0) || o_valid;

  assign req_fire = o_req_valid && i_req_ready;
  assign rsp_fire = i_rsp_valid && (inflight != '0);
  assign out_fire = o_valid && i_ready;

  // Responses owed to a pre-redirect request are dropped
  // while drop_cnt is non-zero; they arrive first (in order).
  assign push = rsp_fire && (drop_cnt == '0) && !i_pc_load;
  assign pop  = out_fire && !i_pc_load;

  always_comb begin
    inflight_nx = inflight;
    unique case ({req_fire, rsp_fire})
      2'b10:   inflight_nx = inflight + OW'(1);
      2'b01:   inflight_nx = inflight - OW'(1);
      default: inflight_nx = inflight;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      fetch_pc <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      pcq_wr   <= '0;
      pcq_rd   <= '0;
      fq_wr    <= '0;
      fq_rd    <= '0;
      fq_cnt   <= '0;
    end else begin
      inflight <= inflight_nx;
      if (req_fire)
        pcq_wr <= pcq_inc(pcq_wr);
      if (rsp_fire)
        pcq_rd <= pcq_inc(pcq_rd);
      if (i_pc_load) begin
        // Everything still outstanding is now stale.
        fetch_pc <= {i_ext_pc[XLEN-1:2], 2'b00};
        drop_cnt <= inflight_nx;
        fq_wr    <= '0;
        fq_rd    <= '0;
        fq_cnt   <= '0;
      end else begin
        if (req_fire)
          fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp_fire && (drop_cnt != '0))
          drop_cnt <= drop_cnt - OW'(1);
        if (push)
          fq_wr <= fq_wr + AW'(1);
        if (pop)
          fq_rd <= fq_rd + AW'(1);
        fq_cnt <= fq_cnt + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (req_fire)
      pcq[pcq_wr] <= fetch_pc;
    if (push) begin
      fq_pc[fq_wr]  <= pcq[pcq_rd];
      fq_ins[fq_wr] <= i_rsp_data;
    end
  end

endmodule

// File: tb/tb_cpu_ifetch_prefetch.sv
// Randomized bench for cpu_ifetch_prefetch against a stream/epoch model.
// Icache model returns in-order data after a random latency.
module tb_cpu_ifetch_prefetch;
  import rapid_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;
  localparam logic [31:0] RPC = RESET_VECTOR;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_pc_load = 1'b0;
  logic [31:0] i_ext_pc = '0;
  logic        i_ready = 1'b0;
  logic        i_req_ready = 1'b0;
  logic        i_rsp_valid = 1'b0;
  logic [31:0] i_rsp_data = '0;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_instruction;
  logic        o_req_valid;
  logic [31:0] o_req_addr;
  logic        o_busy;

  always #5 clk = ~clk;

  cpu_ifetch_prefetch #(
    .XLEN(32),
    .FIFO_DEPTH(DEPTH),
    .MAX_OUTSTANDING(MAXO),
    .RESET_PC(RPC)
  ) dut (
    .i_clk(clk),
    .i_reset(i_reset),
    .i_pc_load(i_pc_load),
    .i_ext_pc(i_ext_pc),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_pc(o_pc),
    .o_instruction(o_instruction),
    .o_req_valid(o_req_valid),
    .i_req_ready(i_req_ready),
    .o_req_addr(o_req_addr),
    .i_rsp_valid(i_rsp_valid),
    .i_rsp_data(i_rsp_data),
    .o_busy(o_busy)
  );

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  req_t        pend[$];
  ent_t        q[$];
  int          epoch = 0;
  int          cyc = 0;
  logic [31:0] mpc = RPC;
  int          lat_lo = 1;
  int          lat_hi = 1;
  int          n_chk = 0;
  int          n_err = 0;
  int          n_acc = 0;
  int          n_dreq = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a * 32'h9E37_79B1 ^ 32'h1357_9BDF;
  endfunction

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic step(
    input bit          rdy,
    input bit          rrdy,
    input bit          rsp_en,
    input bit          load,
    input logic [31:0] tgt
  );
    bit   ev;
    bit   rv;
    bit   rsp;
    int   live;
    req_t r;
    ent_t e;
    live = 0;
    foreach (pend[k])
      if (pend[k].epoch == epoch) live++;
    ev = (q.size() != 0);
    rv = (pend.size() < MAXO) && (live + q.size() < DEPTH);
    if (ev) e = q[0];
    else    e = '{32'h0, NOOP_INSTRUCTION};
    check("o_valid", {31'b0, o_valid}, {31'b0, ev});
    check("o_pc", o_pc, e.pc);
    check("o_instruction", o_instruction, e.ins);
    check("o_req_valid", {31'b0, o_req_valid}, {31'b0, rv});
    if (rv) check("o_req_addr", o_req_addr, mpc);
    check("o_busy", {31'b0, o_busy},
          {31'b0, (pend.size() != 0) || ev});

    rsp = rsp_en && (pend.size() != 0) && (pend[0].due <= cyc);
    i_ready     = rdy;
    i_req_ready = rrdy;
    i_pc_load   = load;
    i_ext_pc    = tgt;
    i_rsp_valid = rsp;
    i_rsp_data  = rsp ? mem(pend[0].addr) : $urandom;
    if (o_valid && rdy && !load) n_acc++;
    if (o_req_valid && rrdy) n_dreq++;

    if (ev && rdy && !load) q.delete(0);
    if (rsp) begin
      r = pend[0];
      pend.delete(0);
      if (r.epoch == epoch && !load)
        q.push_back('{r.addr, mem(r.addr)});
    end
    if (rv && rrdy)
      pend.push_back('{mpc, epoch,
        cyc + int'($urandom_range(lat_hi, lat_lo))});
    if (load) begin
      epoch++;
      q.delete();
      mpc = {tgt[31:2], 2'b00};
    end else if (rv && rrdy) begin
      mpc = mpc + 32'd4;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    i_reset     = 1'b1;
    i_pc_load   = 1'b0;
    i_ready     = 1'b0;
    i_req_ready = 1'b0;
    i_rsp_valid = 1'b0;
    #1;
    check("rst_o_valid", {31'b0, o_valid}, 32'd0);
    check("rst_o_pc", o_pc, 32'd0);
    check("rst_o_instruction", o_instruction, NOOP_INSTRUCTION);
    check("rst_o_req_valid", {31'b0, o_req_valid}, 32'd0);
    check("rst_o_busy", {31'b0, o_busy}, 32'd0);
    pend.delete();
    q.delete();
    mpc = RPC;
    @(posedge clk);
    @(negedge clk);
    i_reset = 1'b0;
    #1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Zero-wait streaming: first hand-off on cycle 2, then 1/cycle.
    lat_lo = 1; lat_hi = 1;
    n_acc = 0;
    for (int i = 0; i < 40; i++) step(1, 1, 1, 0, 0);
    check("stream_cnt", n_acc, 32'd38);

    // Backpressure: only queue-sized reservation may be issued.
    @(negedge clk);
    do_reset();
    n_dreq = 0;
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 0);
    check("bp_requests", n_dreq, DEPTH);
    for (int i = 0; i < 20; i++) step(1, 1, 1, 0, 0);

    // Redirect with slow icache and requests in flight.
    @(negedge clk);
    do_reset();
    lat_lo = 3; lat_hi = 3;
    for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0);
    step(1, 1, 1, 1, 32'h100);
    for (int i = 0; i < 12; i++) step(1, 1, 1, 0, 0);

    // Back-to-back redirects, then drain to idle.
    lat_lo = 1; lat_hi = 2;
    for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 0);
    step(1, 1, 1, 1, 32'h200);
    step(1, 1, 1, 1, 32'h303);
    for (int i = 0; i < 6; i++) step(1, 1, 1, 0, 0);
    for (int i = 0; i < 40 && o_busy; i++)
      step(1, 0, 1, 0, 0);
    check("drain_busy", {31'b0, o_busy}, 32'd0);

    // Randomized traffic with redirects and occasional resets.
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(999, 0) < 3) begin
        do_reset();
      end else begin
        step($urandom_range(9, 0) < 7,
             $urandom_range(9, 0) < 6,
             $urandom_range(9, 0) < 7,
             $urandom_range(99, 0) < 5,
             $urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
